// File: rtl/alu_uart_sequencer_if.sv
// Byte-level bus between the UART, the ALU and the sequencer.
// The sequencer connects through the slave modport.
interface alu_uart_sequencer_if #(
   parameter int SIZEDATA = 8,
   parameter int SIZEOP   = 6
);
   logic [SIZEDATA-1:0] i_rx_data;
   logic                i_rx_done;
   logic [SIZEDATA-1:0] i_alu_result;
   logic                i_tx_done;
   logic [SIZEDATA-1:0] o_datoa;
   logic [SIZEDATA-1:0] o_datob;
   logic [SIZEOP-1:0]   o_opcode;
   logic [SIZEDATA-1:0] o_tx_data;
   logic                o_tx_start;
   logic                o_busy;

   modport master (
      output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
      input  o_datoa, o_datob, o_opcode, o_tx_data, o_tx_start, o_busy
   );

   modport slave (
      input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
      output o_datoa, o_datob, o_opcode, o_tx_data, o_tx_start, o_busy
   );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from the UART, presents them to the ALU
// and forwards the result to the transmitter.
module alu_uart_sequencer #(
   parameter int SIZEDATA = 8,
   parameter int SIZEOP   = 6
) (
   input logic                 i_clock,
   input logic                 i_reset,
   alu_uart_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      LATCH,
      WAIT_TX
   } state_t;

   state_t state;
   state_t next;

   logic [SIZEDATA-1:0] datoa;
   logic [SIZEDATA-1:0] datob;
   logic [SIZEOP-1:0]   opcode;
   logic [SIZEDATA-1:0] tx_data;
   logic                tx_start;
   logic                busy;

   always_ff @(posedge i_clock) begin
      if (i_reset) state <= WAIT_A;
      else         state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         WAIT_A:  if (bus.i_rx_done) next = WAIT_B;
         WAIT_B:  if (bus.i_rx_done) next = WAIT_OP;
         WAIT_OP: if (bus.i_rx_done) next = LATCH;
         LATCH:   next = WAIT_TX;
         WAIT_TX: if (bus.i_tx_done) next = WAIT_A;
         default: next = WAIT_A;
      endcase
   end

   // busy tracks the state register, so it is decoded from the next state
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         datoa    <= '0;
         datob    <= '0;
         opcode   <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         busy     <= 1'b0;
      end else begin
         tx_start <= (state == LATCH);
         busy     <= (next == LATCH) || (next == WAIT_TX);
         if (state == WAIT_A && bus.i_rx_done)
            datoa <= bus.i_rx_data;
         if (state == WAIT_B && bus.i_rx_done)
            datob <= bus.i_rx_data;
         if (state == WAIT_OP && bus.i_rx_done)
            opcode <= bus.i_rx_data[SIZEOP-1:0];
         if (state == LATCH)
            tx_data <= bus.i_alu_result;
      end
   end

   assign bus.o_datoa    = datoa;
   assign bus.o_datob    = datob;
   assign bus.o_opcode   = opcode;
   assign bus.o_tx_data  = tx_data;
   assign bus.o_tx_start = tx_start;
   assign bus.o_busy     = busy;
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: directed test-plan cases plus random
// triples checked against a transaction-level model of the byte protocol.
module tb_alu_uart_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   alu_uart_sequencer_if #(.SIZEDATA(8), .SIZEOP(6)) bus ();

   alu_uart_sequencer #(.SIZEDATA(8), .SIZEOP(6)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // Behavioural stand-in for the team ALU (MIPS-style function codes)
   function automatic logic [7:0] alu(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h02:   return a >> b;
         6'h03:   return 8'($signed(a) >>> b);
         default: return 8'h00;
      endcase
   endfunction

   assign bus.i_alu_result = alu(bus.o_datoa, bus.o_datob, bus.o_opcode);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.i_rx_data = b;
      bus.i_rx_done = 1'b1;
      tick();
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = 8'($urandom);
   endtask

   // One complete transaction: three bytes, then the result hand-off
   task automatic run_triple(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opb, input logic [7:0] exp,
                             input int hold, input int gaps,
                             input bit junk, input string name);
      logic [7:0] held;
      send(a);
      for (int i = 0; i < gaps; i++) begin
         if ($urandom_range(0, 1) == 1) bus.i_tx_done = 1'b1;
         tick();
         bus.i_tx_done = 1'b0;
         checks++;
         if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0)
            $display("FAIL %s gap busy=%b start=%b want 0/0",
                     name, bus.o_busy, bus.o_tx_start);
         else passes++;
      end
      send(b);
      send(opb);
      checks++;
      if (bus.o_datoa !== a || bus.o_datob !== b ||
          bus.o_opcode !== opb[5:0] || bus.o_tx_start !== 1'b0 ||
          bus.o_busy !== 1'b1)
         $display("FAIL %s latch a=%h b=%h op=%h st=%b bz=%b want %h %h %h 0 1",
                  name, bus.o_datoa, bus.o_datob, bus.o_opcode,
                  bus.o_tx_start, bus.o_busy, a, b, opb[5:0]);
      else passes++;
      tick();
      checks++;
      if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== exp ||
          bus.o_busy !== 1'b1)
         $display("FAIL %s start st=%b data=%h bz=%b want 1 %h 1",
                  name, bus.o_tx_start, bus.o_tx_data, bus.o_busy, exp);
      else passes++;
      held = exp;
      for (int i = 0; i < hold; i++) begin
         if (junk) begin
            bus.i_rx_data = 8'hAA;
            bus.i_rx_done = 1'b1;
         end
         tick();
         bus.i_rx_done = 1'b0;
         checks++;
         if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== held ||
             bus.o_busy !== 1'b1 || bus.o_datoa !== a)
            $display("FAIL %s hold%0d st=%b data=%h bz=%b a=%h want 0 %h 1 %h",
                     name, i, bus.o_tx_start, bus.o_tx_data, bus.o_busy,
                     bus.o_datoa, held, a);
         else passes++;
      end
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0 ||
          bus.o_tx_data !== held)
         $display("FAIL %s done bz=%b st=%b data=%h want 0 0 %h",
                  name, bus.o_busy, bus.o_tx_start, bus.o_tx_data, held);
      else passes++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.o_datoa, bus.o_datob, bus.o_opcode, bus.o_tx_data,
           bus.o_tx_start, bus.o_busy} !== '0)
         $display("FAIL reset a=%h b=%h op=%h d=%h st=%b bz=%b want all 0",
                  bus.o_datoa, bus.o_datob, bus.o_opcode, bus.o_tx_data,
                  bus.o_tx_start, bus.o_busy);
      else passes++;
   endtask

   task automatic test_add();
      run_triple(8'h05, 8'h03, 8'h20, 8'h08, 3, 0, 1'b0, "add");
   endtask

   task automatic test_sub_shift();
      run_triple(8'h03, 8'h05, 8'h22, 8'hFE, 0, 1, 1'b0, "sub");
      run_triple(8'h80, 8'h01, 8'h03, 8'hC0, 2, 0, 1'b0, "sra");
      run_triple(8'h80, 8'h01, 8'h02, 8'h40, 1, 2, 1'b0, "srl");
   endtask

   task automatic test_opcode_mask();
      run_triple(8'h0F, 8'hF0, 8'hE5, 8'hFF, 1, 0, 1'b0, "or_mask");
      run_triple(8'h12, 8'h34, 8'h3F, 8'h00, 1, 0, 1'b0, "undef_op");
   endtask

   task automatic test_drop_rx();
      run_triple(8'h11, 8'h22, 8'h20, 8'h33, 4, 0, 1'b1, "junk_busy");
      run_triple(8'h01, 8'h02, 8'h20, 8'h03, 1, 0, 1'b0, "after_junk");
   endtask

   task automatic test_reset_mid();
      send(8'h44);
      send(8'h55);
      rst = 1'b1;
      bus.i_rx_data = 8'h20;
      bus.i_rx_done = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_rx_done = 1'b0;
      checks++;
      if ({bus.o_datoa, bus.o_datob, bus.o_opcode, bus.o_tx_data,
           bus.o_tx_start, bus.o_busy} !== '0)
         $display("FAIL reset_mid a=%h b=%h op=%h d=%h st=%b bz=%b want 0",
                  bus.o_datoa, bus.o_datob, bus.o_opcode, bus.o_tx_data,
                  bus.o_tx_start, bus.o_busy);
      else passes++;
      run_triple(8'h07, 8'h01, 8'h20, 8'h08, 1, 0, 1'b0, "post_reset");
   endtask

   task automatic test_long_hold();
      run_triple(8'h09, 8'h06, 8'h26, 8'h0F, 50, 0, 1'b0, "hold50");
   endtask

   task automatic test_random();
      logic [7:0] ops [8];
      logic [7:0] a, b, opb;
      ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
      for (int t = 0; t < 25; t++) begin
         a   = 8'($urandom);
         b   = 8'($urandom_range(0, 255));
         opb = ($urandom_range(0, 5) == 0) ? 8'($urandom)
                                          : ops[$urandom_range(0, 7)];
         opb[7:6] = 2'($urandom);
         run_triple(a, b, opb, alu(a, b, opb[5:0]),
                    $urandom_range(0, 6), $urandom_range(0, 2),
                    1'($urandom), $sformatf("rand%0d", t));
      end
   endtask

   initial begin
      bus.i_rx_data = '0;
      bus.i_rx_done = 1'b0;
      bus.i_tx_done = 1'b0;
      test_reset();
      test_add();
      test_sub_shift();
      test_opcode_mask();
      test_drop_rx();
      test_reset_mid();
      test_long_hold();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
- Glue block between the UART receiver/transmitter and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them to the ALU as registered values.
- Captures the ALU result and hands it to the UART transmitter with a one-cycle start pulse.
- Waits for transmit completion before accepting the next operand set.

Parameters:
- SIZEDATA, 8, width of operands, result and UART data bytes.
- SIZEOP, 6, opcode width; taken from the low SIZEOP bits of the opcode byte.

Ports:
- i_clock  input  1  system clock; all state changes on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_rx_data  input  SIZEDATA  byte from the UART receiver; valid only when i_rx_done=1.
- i_rx_done  input  1  one-cycle pulse: i_rx_data holds a new byte.
- i_alu_result  input  SIZEDATA  combinational ALU output.
- i_tx_done  input  1  one-cycle pulse from the transmitter: byte fully sent.
- o_datoa  output  SIZEDATA  registered operand A to the ALU.
- o_datob  output  SIZEDATA  registered operand B to the ALU.
- o_opcode  output  SIZEOP  registered opcode to the ALU.
- o_tx_data  output  SIZEDATA  registered result byte to the transmitter.
- o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
- o_busy  output  1  high in LATCH and WAIT_TX states.

Behaviour:
- Reset:
  - Sampled on the rising edge of i_clock only; highest priority over every other event.
  - State goes to WAIT_A.
  - o_datoa, o_datob, o_opcode, o_tx_data are 0; o_tx_start=0; o_busy=0.
  - Reset mid-sequence discards partially collected operands.
- States: WAIT_A, WAIT_B, WAIT_OP, LATCH, WAIT_TX.
- WAIT_A: on i_rx_done=1, o_datoa <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done=1, o_datob <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done=1, o_opcode <= i_rx_data[SIZEOP-1:0], go to LATCH. Upper byte bits are ignored.
- LATCH (exactly one cycle):
  - The ALU output already reflects the registered operands and opcode.
  - At the edge: o_tx_data <= i_alu_result, o_tx_start <= 1, go to WAIT_TX.
- WAIT_TX:
  - o_tx_start is high only during the first WAIT_TX cycle, then cleared.
  - On i_tx_done=1 go to WAIT_A; this includes i_tx_done arriving in the same cycle as o_tx_start.
  - o_datoa, o_datob, o_opcode and o_tx_data hold their values until overwritten by the next sequence.
- Latency: the opcode byte's i_rx_done in cycle N gives o_tx_start=1 in cycle N+2, with o_tx_data already valid in N+2.
- Ignored events:
  - i_rx_done in LATCH or WAIT_TX is dropped; no buffering. Those bytes are not counted toward the next triple.
  - i_tx_done outside WAIT_TX has no effect.
- o_busy is a registered decode of the state (LATCH or WAIT_TX). It is 0 in the WAIT_A, WAIT_B and WAIT_OP states.
- Data: no arithmetic inside the block. Values pass through unmodified. An undefined opcode is forwarded as is; the ALU yields 0 and 0x00 is transmitted.
- No timeout: the block waits indefinitely in any WAIT_* state.

Test Plan:
Bench instantiates the sequencer with the team ALU; rx_done/tx_done pulses are driven by the bench.
1. Bytes 0x05, 0x03, 0x20 (ADD) -> o_datoa=0x05, o_datob=0x03, o_opcode=0x20; o_tx_start pulses once 2 cycles after the third rx_done; o_tx_data=0x08; o_busy=1 until tx_done.
2. Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE. Then bytes 0x80, 0x01, 0x03 (SRA) -> o_tx_data=0xC0. Then 0x80, 0x01, 0x02 (SRL) -> 0x40.
3. Opcode byte 0xE5 -> o_opcode=0x25 (OR); A=0x0F, B=0xF0 -> o_tx_data=0xFF. Undefined opcode 0x3F -> o_tx_data=0x00.
4. Send 0xAA via rx_done while in WAIT_TX, then tx_done, then 0x01, 0x02, 0x20 -> 0xAA never appears on o_datoa; result 0x03; exactly one o_tx_start per triple.
5. Assert i_reset after A and B (in WAIT_OP), together with an rx_done -> next edge: all outputs 0, state WAIT_A. A following triple 0x07, 0x01, 0x20 -> o_tx_data=0x08.
6. Hold off i_tx_done for 50 cycles -> o_tx_start high exactly 1 cycle; o_tx_data stable; o_busy stays 1. After tx_done, o_busy=0 the next cycle.
